// File: rtl/dpram_pkg.sv
// Shared constants and FSM state type for the 32x32 dual-port RAM engines.
// Used by the read-side stream engine and its FIFO.
package dpram_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned LEN_W  = ADDR_W + 1;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_e;

endpackage

// File: rtl/dpram_stream_reader_if.sv
// Bundles the command, RAM read port, output stream and status signals of the reader.
// slave = the reader engine; master = the surrounding environment (RAM, consumer, host).
interface dpram_stream_reader_if #(
   parameter int unsigned DATA_W = dpram_pkg::DATA_W,
   parameter int unsigned ADDR_W = dpram_pkg::ADDR_W,
   parameter int unsigned LEN_W  = dpram_pkg::LEN_W
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
      output cmd_ready, mem_en, mem_addr, out_valid, out_data, out_last, busy, done
   );

   modport master (
      output cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
      input  cmd_ready, mem_en, mem_addr, out_valid, out_data, out_last, busy, done
   );
endinterface

// File: rtl/dpram_stream_reader_fifo2.sv
// Two-entry in-order valid/ready buffer carrying a data word plus its last-beat flag.
// Head entry always sits in slot 0 so the output is a plain register.
module stream_fifo2 #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o,
   output logic [1:0]        count_o
);
   logic [DATA_W:0] slot_q [2];
   logic [1:0]      count_q;
   logic            pop;
   logic            wr;

   assign pop = (count_q != 2'd0) & ready_i;
   // A push into a full buffer is only taken when the head leaves in the same cycle.
   assign wr  = push_i & ((count_q != 2'd2) | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         slot_q[0] <= '0;
         slot_q[1] <= '0;
      end else begin
         if (pop) begin
            slot_q[0] <= slot_q[1];
         end
         if (wr) begin
            if (pop && count_q == 2'd2) begin
               slot_q[1] <= {last_i, data_i};
            end else if (pop) begin
               slot_q[0] <= {last_i, data_i};
            end else begin
               slot_q[count_q[0]] <= {last_i, data_i};
            end
         end
         count_q <= count_q + {1'b0, wr} - {1'b0, pop};
      end
   end

   assign valid_o = (count_q != 2'd0);
   assign data_o  = slot_q[0][DATA_W-1:0];
   assign last_o  = slot_q[0][DATA_W];
   assign count_o = count_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Burst read engine: walks the RAM read port one address per cycle and streams the words
// out through a 2-entry buffer with last-beat marking and a completion pulse.
module dpram_stream_reader #(
   parameter int unsigned DATA_W = dpram_pkg::DATA_W,
   parameter int unsigned ADDR_W = dpram_pkg::ADDR_W,
   parameter int unsigned LEN_W  = dpram_pkg::LEN_W
) (
   input logic                  clk,
   input logic                  rst,
   dpram_stream_reader_if.slave bus
);
   import dpram_pkg::*;

   state_e            state_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [LEN_W-1:0]  remaining_q;
   logic              cmd_ready_q;
   logic              busy_q;
   logic              done_q;

   logic              fifo_valid;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_last;
   logic [1:0]        fifo_count;

   logic              pop;
   logic              issue;
   logic              push;
   logic              cmd_fire;
   logic              last_issue;

   always_comb begin
      pop        = fifo_valid & bus.out_ready;
      issue      = (fifo_count < 2'd2) | pop;
      push       = (state_q == READ) & issue;
      cmd_fire   = bus.cmd_valid & cmd_ready_q;
      last_issue = (remaining_q == LEN_W'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         remaining_q <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cmd_fire) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus.cmd_len != '0) begin
                     state_q     <= READ;
                     mem_addr_q  <= bus.cmd_addr;
                     remaining_q <= bus.cmd_len;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            READ: begin
               // Address counter wraps naturally at 2**ADDR_W.
               if (issue) begin
                  mem_addr_q  <= mem_addr_q + 1'b1;
                  remaining_q <= remaining_q - 1'b1;
                  if (last_issue) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && fifo_last) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   stream_fifo2 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (bus.mem_rdata),
      .last_i  (last_issue),
      .ready_i (bus.out_ready),
      .valid_o (fifo_valid),
      .data_o  (fifo_data),
      .last_o  (fifo_last),
      .count_o (fifo_count)
   );

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.mem_en    = push;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_valid = fifo_valid;
   assign bus.out_data  = fifo_data;
   assign bus.out_last  = fifo_last;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Randomised self-checking bench for dpram_stream_reader against a RAM model and an
// address-walk reference of expected bursts.
module tb_dpram_stream_reader;

   logic clk;
   logic rst;
   dpram_stream_reader_if bus ();

   dpram_stream_reader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] ram [32];
   assign bus.mem_rdata = ram[bus.mem_addr];

   int tests_run;
   int failed;

   logic [31:0] got_data [$];
   logic        got_last [$];
   logic [4:0]  got_addr [$];
   int          memen_cnt;
   int          done_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_last.push_back(bus.out_last);
         end
         if (bus.mem_en) begin
            memen_cnt++;
            got_addr.push_back(bus.mem_addr);
         end
         if (bus.done) done_cnt++;
      end
   end

   function automatic logic [31:0] init_word(input int i);
      return (32'h1111_1111 * 32'(i % 16)) | 32'(i);
   endfunction

   function automatic logic [31:0] exp_word(input int addr, input int k);
      return ram[(addr + k) % 32];
   endfunction

   task automatic clear_log();
      got_data.delete();
      got_last.delete();
      got_addr.delete();
      memen_cnt = 0;
      done_cnt  = 0;
   endtask

   task automatic send_cmd(input int addr, input int len, output bit ok);
      ok = 1'b0;
      bus.cmd_addr  = 5'(addr);
      bus.cmd_len   = 6'(len);
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit rnd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      bit ok;
      @(negedge clk);
      tests_run++;
      if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
         failed++;
         $display("FAIL reset_state: cmd_ready=%b busy=%b out_valid=%b mem_en=%b, want 1 0 0 0",
                  bus.cmd_ready, bus.busy, bus.out_valid, bus.mem_en);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      send_cmd(3, 8, ok);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      tests_run++;
      if (bus.cmd_ready !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_addr !== 5'd0 || bus.out_valid !== 1'b0 ||
          bus.out_data !== 32'd0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failed++;
         $display("FAIL async_reset: rdy=%b en=%b addr=%0d vld=%b data=%h last=%b busy=%b done=%b, want 1 0 0 0 0 0 0 0",
                  bus.cmd_ready, bus.mem_en, bus.mem_addr, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.cmd_ready !== 1'b1) begin
         failed++;
         $display("FAIL ready_after_reset: cmd_ready=%b want 1", bus.cmd_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      bit ok;
      clear_log();
      send_cmd(4, 3, ok);
      tests_run++;
      if (!ok) begin failed++; $display("FAIL basic_cmd: accepted=0 want 1"); end
      @(negedge clk);
      tests_run++;
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== 5'd4 || bus.out_valid !== 1'b0) begin
         failed++;
         $display("FAIL basic_issue: mem_en=%b mem_addr=%0d out_valid=%b want 1 4 0", bus.mem_en, bus.mem_addr, bus.out_valid);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== ram[4 + k] || bus.out_last !== 1'(k == 2)) begin
            failed++;
            $display("FAIL basic_beat%0d: valid=%b data=%h last=%b want 1 %h %b",
                     k, bus.out_valid, bus.out_data, bus.out_last, ram[4 + k], k == 2);
         end
      end
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
         failed++;
         $display("FAIL basic_done: done=%b out_valid=%b want 1 0", bus.done, bus.out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         failed++;
         $display("FAIL basic_idle: done=%b cmd_ready=%b busy=%b want 0 1 0", bus.done, bus.cmd_ready, bus.busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_wrap();
      bit ok;
      clear_log();
      send_cmd(30, 4, ok);
      run_until_done(50, 1'b0, ok);
      @(posedge clk);
      #1;
      tests_run++;
      if (!ok || done_cnt != 1) begin failed++; $display("FAIL wrap_done: seen=%b pulses=%0d want 1 1", ok, done_cnt); end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (k >= got_addr.size() || k >= got_data.size()) begin
            failed++;
            $display("FAIL wrap_beat%0d: missing, got %0d addrs %0d words want 4", k, got_addr.size(), got_data.size());
         end else if (got_addr[k] !== 5'((30 + k) % 32) || got_data[k] !== exp_word(30, k) || got_last[k] !== 1'(k == 3)) begin
            failed++;
            $display("FAIL wrap_beat%0d: addr=%0d data=%h last=%b want %0d %h %b",
                     k, got_addr[k], got_data[k], got_last[k], (30 + k) % 32, exp_word(30, k), k == 3);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      bit found;
      logic [31:0] held;
      clear_log();
      send_cmd(0, 10, ok);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready && bus.out_data === ram[1]) begin
            found = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!found) begin failed++; $display("FAIL bp_beat2: not seen want ram[1]=%h", ram[1]); end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      held = '0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         if (s == 0) held = bus.out_data;
         else begin
            tests_run++;
            if (bus.mem_en !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== held || held !== ram[2]) begin
               failed++;
               $display("FAIL bp_stall%0d: mem_en=%b valid=%b data=%h held=%h want 0 1 %h",
                        s, bus.mem_en, bus.out_valid, bus.out_data, held, ram[2]);
            end
         end
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      run_until_done(60, 1'b0, ok);
      @(posedge clk);
      #1;
      tests_run++;
      if (!ok || done_cnt != 1 || memen_cnt != 10 || got_data.size() != 10) begin
         failed++;
         $display("FAIL bp_counts: done=%b pulses=%0d mem_en=%0d words=%0d want 1 1 10 10",
                  ok, done_cnt, memen_cnt, got_data.size());
      end
      for (int k = 0; k < 10 && k < got_data.size(); k++) begin
         tests_run++;
         if (got_data[k] !== exp_word(0, k) || got_last[k] !== 1'(k == 9)) begin
            failed++;
            $display("FAIL bp_word%0d: data=%h last=%b want %h %b", k, got_data[k], got_last[k], exp_word(0, k), k == 9);
         end
      end
      clear_log();
      send_cmd(7, 32, ok);
      run_until_done(600, 1'b1, ok);
      @(posedge clk);
      #1;
      tests_run++;
      if (!ok || done_cnt != 1 || memen_cnt != 32 || got_data.size() != 32) begin
         failed++;
         $display("FAIL full_counts: done=%b pulses=%0d mem_en=%0d words=%0d want 1 1 32 32",
                  ok, done_cnt, memen_cnt, got_data.size());
      end
      for (int k = 0; k < 32 && k < got_data.size() && k < got_addr.size(); k++) begin
         tests_run++;
         if (got_addr[k] !== 5'((7 + k) % 32) || got_data[k] !== exp_word(7, k) || got_last[k] !== 1'(k == 31)) begin
            failed++;
            $display("FAIL full_word%0d: addr=%0d data=%h last=%b want %0d %h %b",
                     k, got_addr[k], got_data[k], got_last[k], (7 + k) % 32, exp_word(7, k), k == 31);
         end
      end
   endtask

   task automatic test_empty();
      bit ok;
      clear_log();
      send_cmd(5, 0, ok);
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.cmd_ready !== 1'b0) begin
         failed++;
         $display("FAIL empty_done: done=%b valid=%b mem_en=%b cmd_ready=%b want 1 0 0 0",
                  bus.done, bus.out_valid, bus.mem_en, bus.cmd_ready);
      end
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         failed++;
         $display("FAIL empty_idle: done=%b cmd_ready=%b busy=%b want 0 1 0", bus.done, bus.cmd_ready, bus.busy);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (memen_cnt != 0 || got_data.size() != 0 || done_cnt != 1) begin
         failed++;
         $display("FAIL empty_counts: mem_en=%0d words=%0d pulses=%0d want 0 0 1", memen_cnt, got_data.size(), done_cnt);
      end
   endtask

   task automatic test_reset_midburst();
      bit ok;
      bit found;
      clear_log();
      send_cmd(9, 20, ok);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_data === ram[13]) begin
            found = 1'b1;
            break;
         end
      end
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if (!found || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         failed++;
         $display("FAIL mid_reset: beat5_seen=%b valid=%b busy=%b cmd_ready=%b want 1 0 0 1",
                  found, bus.out_valid, bus.busy, bus.cmd_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_log();
      repeat (5) @(posedge clk);
      #1;
      tests_run++;
      if (done_cnt != 0 || memen_cnt != 0 || bus.out_valid !== 1'b0) begin
         failed++;
         $display("FAIL mid_quiet: pulses=%0d mem_en=%0d valid=%b want 0 0 0", done_cnt, memen_cnt, bus.out_valid);
      end
      clear_log();
      send_cmd(2, 1, ok);
      run_until_done(20, 1'b0, ok);
      @(posedge clk);
      #1;
      tests_run++;
      if (!ok || got_data.size() != 1 || (got_data.size() == 1 && (got_data[0] !== ram[2] || got_last[0] !== 1'b1))) begin
         failed++;
         $display("FAIL post_reset_burst: done=%b words=%0d first=%h want 1 1 %h with last",
                  ok, got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0, ram[2]);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int addr;
      int len;
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < 4; j++) ram[$urandom_range(0, 31)] = $urandom;
         addr = $urandom_range(0, 31);
         len  = $urandom_range(0, 32);
         clear_log();
         send_cmd(addr, len, ok);
         run_until_done(600, 1'b1, ok);
         @(posedge clk);
         #1;
         tests_run++;
         if (!ok || done_cnt != 1 || memen_cnt != len || got_data.size() != len) begin
            failed++;
            $display("FAIL b2b%0d_counts: addr=%0d len=%0d done=%b pulses=%0d mem_en=%0d words=%0d want 1 1 %0d %0d",
                     b, addr, len, ok, done_cnt, memen_cnt, got_data.size(), len, len);
         end
         for (int k = 0; k < len && k < got_data.size(); k++) begin
            tests_run++;
            if (got_data[k] !== exp_word(addr, k) || got_last[k] !== 1'(k == len - 1)) begin
               failed++;
               $display("FAIL b2b%0d_word%0d: data=%h last=%b want %h %b",
                        b, k, got_data[k], got_last[k], exp_word(addr, k), k == len - 1);
            end
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", tests_run, failed + 1);
      $fatal(1);
   end

   initial begin
      tests_run = 0;
      failed    = 0;
      clear_log();
      for (int i = 0; i < 32; i++) ram[i] = init_word(i);
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_empty();
      test_reset_midburst();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
